// File: rtl/bo_pkg.sv
// Shared definitions for the polynomial datapath (BO) and its control block.
package bo_pkg;

    // Data width of the BO registers and ULA; arithmetic wraps modulo 2^DATA_W.
    localparam int DATA_W = 16;

    // Control FSM states; 3'd7 is unused and treated as illegal.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MUL1  = 3'd2,
        ADD_B = 3'd3,
        MUL2  = 3'd4,
        ADD_C = 3'd5,
        DONE  = 3'd6
    } state_e;

    // ULA operand-1 select (m0).
    localparam logic [1:0] M0_RX = 2'b00;
    localparam logic [1:0] M0_A  = 2'b01;
    localparam logic [1:0] M0_B  = 2'b10;
    localparam logic [1:0] M0_C  = 2'b11;

    // ULA operand-2 select (m1).
    localparam logic [1:0] M1_RH   = 2'b00;
    localparam logic [1:0] M1_RX   = 2'b01;
    localparam logic [1:0] M1_ZERO = 2'b10;
    localparam logic [1:0] M1_B    = 2'b11;

    // R_H input select (m2); 2'b11 is reserved.
    localparam logic [1:0] M2_ULA  = 2'b00;
    localparam logic [1:0] M2_A    = 2'b01;
    localparam logic [1:0] M2_ZERO = 2'b10;

    // ULA operation (h).
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    // Bundle of every control output driven towards BO plus the handshake.
    typedef struct packed {
        logic       busy;
        logic       done;
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       lx;
        logic       ls;
        logic       lh;
        logic       h;
    } ctrl_t;

    // Moore decode: outputs for a state, given whether the wait counter is on
    // its final cycle. Load strobes in ULA states fire only on that cycle.
    function automatic ctrl_t ctrl_decode(input state_e st, input logic last);
        ctrl_t c;
        c = '0;
        case (st)
            LOAD: begin
                c.busy = 1'b1;
                c.lx   = 1'b1;
                c.lh   = 1'b1;
                c.m2   = M2_A;
            end
            MUL1, MUL2: begin
                c.busy = 1'b1;
                c.m0   = M0_RX;
                c.m1   = M1_RH;
                c.m2   = M2_ULA;
                c.h    = OP_MUL;
                c.lh   = last;
            end
            ADD_B: begin
                c.busy = 1'b1;
                c.m0   = M0_B;
                c.m1   = M1_RH;
                c.m2   = M2_ULA;
                c.h    = OP_ADD;
                c.lh   = last;
            end
            ADD_C: begin
                c.busy = 1'b1;
                c.m0   = M0_C;
                c.m1   = M1_RH;
                c.m2   = M2_ULA;
                c.h    = OP_ADD;
                c.lh   = last;
                c.ls   = last;
            end
            DONE: begin
                c.done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/contador_espera.sv
// Wait counter that times each ULA state: counts up while enabled, clears on
// request, and flags the terminal count ULA_LAT-1 for the current and next cycle.
module contador_espera #(
    parameter int ULA_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last,
    output logic last_nxt
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(ULA_LAT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over enable, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // last_nxt lets the FSM register its strobes for the coming cycle.
    assign last     = (cnt_q == TERM);
    assign last_nxt = (cnt_d == TERM);

endmodule

// File: rtl/bc_horner.sv
// Control block for BO: sequences mux selects, loads and ULA op so BO computes
// S = A*X^2 + B*X + C by Horner (H=A; H*=X; H+=B; H*=X; S=H+C).
// Handshake: start is sampled only in IDLE; busy covers LOAD..ADD_C; done is a
// one-cycle pulse when S holds the result. Starts seen elsewhere are dropped.
module bc_horner
    import bo_pkg::*;
#(
    parameter int ULA_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [1:0] m0,
    output logic [1:0] m1,
    output logic [1:0] m2,
    output logic       lx,
    output logic       ls,
    output logic       lh,
    output logic       h,
    output state_e     dbg_state
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_d;
    logic   cnt_clr;
    logic   cnt_en;
    logic   cnt_last;
    logic   cnt_last_nxt;

    contador_espera #(
        .ULA_LAT (ULA_LAT),
        .CNT_W   (CNT_W)
    ) u_contador_espera (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .last     (cnt_last),
        .last_nxt (cnt_last_nxt)
    );

    // Next state and counter control; outputs are decoded from the next state
    // so they can be registered and still line up with the state register.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (start) state_d = LOAD;
            end
            LOAD: begin
                cnt_clr = 1'b1;
                state_d = MUL1;
            end
            MUL1: begin
                if (cnt_last) begin
                    cnt_clr = 1'b1;
                    state_d = ADD_B;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ADD_B: begin
                if (cnt_last) begin
                    cnt_clr = 1'b1;
                    state_d = MUL2;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            MUL2: begin
                if (cnt_last) begin
                    cnt_clr = 1'b1;
                    state_d = ADD_C;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ADD_C: begin
                if (cnt_last) begin
                    cnt_clr = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
        ctrl_d = ctrl_decode(state_d, cnt_last_nxt);
    end

    // State and registered outputs; reset forces IDLE with every output low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign busy      = ctrl_q.busy;
    assign done      = ctrl_q.done;
    assign m0        = ctrl_q.m0;
    assign m1        = ctrl_q.m1;
    assign m2        = ctrl_q.m2;
    assign lx        = ctrl_q.lx;
    assign ls        = ctrl_q.ls;
    assign lh        = ctrl_q.lh;
    assign h         = ctrl_q.h;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bc_horner.sv
// Bench for bc_horner: two instances (ULA_LAT=1 and ULA_LAT=3), each driving a
// behavioural BO model, exercised by directed steps with hand-computed results.
module tb_bc_horner;
    import bo_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT 1 (ULA_LAT=1) ----------------
    logic        start1;
    logic        busy1, done1, lx1, ls1, lh1, h1;
    logic [1:0]  m0_1, m1_1, m2_1;
    state_e      st1;
    logic [15:0] a1, b1, c1, x1;
    logic [15:0] rx1 = 16'h0;
    logic [15:0] rh1 = 16'h0;
    logic [15:0] s1  = 16'hDEAD;
    logic [11:0] out1;

    bc_horner #(.ULA_LAT(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .m0(m0_1), .m1(m1_1), .m2(m2_1), .lx(lx1), .ls(ls1), .lh(lh1), .h(h1),
        .dbg_state(st1)
    );

    // ---------------- DUT 3 (ULA_LAT=3) ----------------
    logic        start3;
    logic        busy3, done3, lx3, ls3, lh3, h3;
    logic [1:0]  m0_3, m1_3, m2_3;
    state_e      st3;
    logic [15:0] a3, b3, c3, x3;
    logic [15:0] rx3 = 16'h0;
    logic [15:0] rh3 = 16'h0;
    logic [15:0] s3  = 16'hDEAD;
    logic [11:0] out3;

    bc_horner #(.ULA_LAT(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
        .m0(m0_3), .m1(m1_3), .m2(m2_3), .lx(lx3), .ls(ls3), .lh(lh3), .h(h3),
        .dbg_state(st3)
    );

    assign out1 = {busy1, done1, m0_1, m1_1, m2_1, lx1, ls1, lh1, h1};
    assign out3 = {busy3, done3, m0_3, m1_3, m2_3, lx3, ls3, lh3, h3};

    // ---------------- behavioural BO ----------------
    function automatic logic [15:0] ula_f(input logic [1:0] sel0, input logic [1:0] sel1,
                                          input logic op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] c,
                                          input logic [15:0] rx, input logic [15:0] rh);
        logic [15:0] o1, o2;
        case (sel0)
            2'b00:   o1 = rx;
            2'b01:   o1 = a;
            2'b10:   o1 = b;
            default: o1 = c;
        endcase
        case (sel1)
            2'b00:   o2 = rh;
            2'b01:   o2 = rx;
            2'b10:   o2 = 16'h0;
            default: o2 = b;
        endcase
        return op ? 16'(o1 * o2) : 16'(o1 + o2);
    endfunction

    logic [15:0] ula1, ula3;
    assign ula1 = ula_f(m0_1, m1_1, h1, a1, b1, c1, rx1, rh1);
    assign ula3 = ula_f(m0_3, m1_3, h3, a3, b3, c3, rx3, rh3);

    always @(posedge clk) begin
        if (lx1) rx1 <= x1;
        if (lh1) rh1 <= (m2_1 == 2'b01) ? a1 : (m2_1 == 2'b10) ? 16'h0 : ula1;
        if (ls1) s1 <= ula1;
        if (lx3) rx3 <= x3;
        if (lh3) rh3 <= (m2_3 == 2'b01) ? a3 : (m2_3 == 2'b10) ? 16'h0 : ula3;
        if (ls3) s3 <= ula3;
    end

    // ---------------- scoreboard ----------------
    int total  = 0;
    int passed = 0;
    int fails  = 0;

    logic [31:0] busy_m, done_m, lx_m, ls_m, lh_m, h_m;
    logic [11:0] acc1, acc3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_masks();
        busy_m = '0; done_m = '0; lx_m = '0; ls_m = '0; lh_m = '0; h_m = '0;
    endtask

    // Record which cycle index n (relative to the start edge) each strobe is high in.
    task automatic sample(input int which, input int n);
        logic [11:0] o;
        o = (which == 1) ? out1 : out3;
        if (o[11]) busy_m[n] = 1'b1;
        if (o[10]) done_m[n] = 1'b1;
        if (o[3])  lx_m[n]   = 1'b1;
        if (o[2])  ls_m[n]   = 1'b1;
        if (o[1])  lh_m[n]   = 1'b1;
        if (o[0])  h_m[n]    = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
        a1 = '0; b1 = '0; c1 = '0; x1 = '0;
        a3 = '0; b3 = '0; c3 = '0; x3 = '0;
        tick();
        tick();

        // Reset state
        check("reset_out1", {20'h0, out1}, 32'h0);
        check("reset_out3", {20'h0, out3}, 32'h0);
        check("reset_state1", {29'h0, st1}, {29'h0, IDLE});
        rst = 1'b0;

        // Test 6: idle for 20 cycles with no start
        acc1 = '0; acc3 = '0;
        for (int n = 1; n <= 20; n++) begin
            acc1 |= out1;
            acc3 |= out3;
            tick();
        end
        check("t6_idle_out1", {20'h0, acc1}, 32'h0);
        check("t6_idle_out3", {20'h0, acc3}, 32'h0);

        // Test 1: ULA_LAT=1, 2*25 + 3*5 + 4 = 69
        a1 = 16'd2; b1 = 16'd3; c1 = 16'd4; x1 = 16'd5;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        clear_masks();
        for (int n = 1; n <= 20; n++) begin
            sample(1, n);
            tick();
        end
        check("t1_done", done_m, 32'h0000_0040);
        check("t1_busy", busy_m, 32'h0000_003E);
        check("t1_lx",   lx_m,   32'h0000_0002);
        check("t1_ls",   ls_m,   32'h0000_0020);
        check("t1_lh",   lh_m,   32'h0000_003E);
        check("t1_s",    {16'h0, s1}, 32'd69);

        // Test 2: ULA_LAT=3, 1*0x100*0x100 wraps to 0
        a3 = 16'd1; b3 = 16'd0; c3 = 16'd0; x3 = 16'h0100;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        clear_masks();
        for (int n = 1; n <= 20; n++) begin
            sample(3, n);
            if (n == 12) check("t2_m0_addc", {30'h0, m0_3}, 32'h3);
            tick();
        end
        check("t2_done", done_m, 32'h0000_4000);
        check("t2_busy", busy_m, 32'h0000_3FFE);
        check("t2_lh",   lh_m,   32'h0000_2492);
        check("t2_h",    h_m,    32'h0000_071C);
        check("t2_ls",   ls_m,   32'h0000_2000);
        check("t2_s",    {16'h0, s3}, 32'h0);

        // Test 3: reset in the 2nd cycle of MUL2, then 1*4 + 1*2 + 1 = 7
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            if (n == 9) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        check("t3_rst_out",   {20'h0, out3}, 32'h0);
        check("t3_rst_state", {29'h0, st3}, {29'h0, IDLE});
        tick();
        check("t3_stay_idle", {20'h0, out3}, 32'h0);
        a3 = 16'd1; b3 = 16'd1; c3 = 16'd1; x3 = 16'd2;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        clear_masks();
        for (int n = 1; n <= 20; n++) begin
            sample(3, n);
            tick();
        end
        check("t3_done", done_m, 32'h0000_4000);
        check("t3_ls",   ls_m,   32'h0000_2000);
        check("t3_s",    {16'h0, s3}, 32'd7);

        // Test 4: start pulsed again during ADD_B is ignored
        a1 = 16'd3; b1 = 16'h1000; c1 = 16'hFFFF; x1 = 16'h0010;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        clear_masks();
        for (int n = 1; n <= 20; n++) begin
            sample(1, n);
            start1 = (n == 3);
            tick();
        end
        start1 = 1'b0;
        check("t4_done", done_m, 32'h0000_0040);
        check("t4_busy", busy_m, 32'h0000_003E);
        check("t4_lx",   lx_m,   32'h0000_0002);
        check("t4_s",    {16'h0, s1}, 32'h0000_02FF);

        // Test 5: start held for three back-to-back runs, 1*16 + 2*4 + 3 = 27
        a1 = 16'd1; b1 = 16'd2; c1 = 16'd3; x1 = 16'd4;
        start1 = 1'b1;
        tick();
        clear_masks();
        for (int n = 1; n <= 21; n++) begin
            sample(1, n);
            if (n == 21) start1 = 1'b0;
            tick();
        end
        check("t5_done", done_m, 32'h0010_2040);
        check("t5_busy", busy_m, 32'h000F_9F3E);
        check("t5_lx",   lx_m,   32'h0000_8102);
        check("t5_ls",   ls_m,   32'h0008_1020);
        check("t5_s",    {16'h0, s1}, 32'd27);
        tick();
        check("t5_back_idle", {20'h0, out1}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bc_horner.md
Name: bc_horner

Overview:
- Control block (bloco de controle) for the polynomial datapath BO.
- Sequences BO's mux selects, register loads and ULA op so that BO computes S = A*X^2 + B*X + C by Horner's method: H=A; H=H*X; H=H+B; H=H*X; S=H+C.
- Presents a start/busy/done handshake to the surrounding system and drives only BO control inputs; no data passes through it.

Parameters:
- ULA_LAT, 1, cycles each ULA operation is held before its result is loaded (1..15).
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > ULA_LAT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a computation; sampled only in IDLE.
- busy  out  1  high from LOAD through ADD_C inclusive.
- done  out  1  one-cycle pulse; S register holds the result.
- m0  out  2  ULA operand-1 select: 00=R_X, 01=A, 10=B, 11=C.
- m1  out  2  ULA operand-2 select: 00=R_H, 01=R_X, 10=zero, 11=B.
- m2  out  2  R_H input select: 00=ULA out, 01=A, 10=zero, 11=reserved.
- lx  out  1  load R_X from Xis.
- ls  out  1  load result register S from ULA out.
- lh  out  1  load R_H through m2.
- h  out  1  ULA op: 0=add, 1=multiply.

Behaviour:
- One clock domain. rst is synchronous and active-high; clk and rst are named as in the rest of the codebase.
- States: IDLE, LOAD, MUL1, ADD_B, MUL2, ADD_C, DONE. Encoding comes from the package.
- Outputs are Moore, decoded from state and wait counter. Unlisted outputs are 0, and mux selects are 00.
- Reset (also mid-operation): next state IDLE, counter=0. busy, done, lx, ls, lh, h are 0 and m0/m1/m2 are 00 in the cycle after the reset edge.
- IDLE: start=1 at an edge moves to LOAD; otherwise stay in IDLE.
- LOAD (1 cycle): lx=1, lh=1, m2=01 (R_X<=Xis, R_H<=A). Counter cleared. Next state MUL1.
- MUL1 and MUL2: m0=00, m1=00, h=1, m2=00.
- ADD_B: m0=10, m1=00, h=0, m2=00.
- ADD_C: m0=11, m1=00, h=0, m2=00; lh and ls are asserted together in this state.
- Each ULA state lasts exactly ULA_LAT cycles:
  - The counter increments each cycle while in the state.
  - Load strobes (lh, and ls in ADD_C) are asserted only in the final cycle, when counter == ULA_LAT-1.
  - The counter clears on every state change.
  - Selects and h are stable for the whole state.
- Transitions: MUL1->ADD_B->MUL2->ADD_C->DONE.
- DONE (1 cycle): done=1, busy=0. Next state IDLE.
- start held high continuously: a new computation begins at the edge after DONE, via IDLE. Back-to-back period is 4*ULA_LAT+3 cycles.
- start while busy or in DONE is ignored; no queuing.
- Latency: start sampled at edge t gives LOAD in cycle t+1 and done in cycle t+4*ULA_LAT+2.
- Exactly one ls pulse per computation. lx pulses only in LOAD.
- Arithmetic is performed in BO, 16-bit, wrapping modulo 2^16. This block adds no width rules.
- Illegal state encodings go to IDLE on the next edge.

Decomposition:
- Package bo_pkg holds:
  - state typedef/encoding;
  - m0, m1, m2 select-code constants;
  - ULA op constants (OP_ADD=0, OP_MUL=1);
  - data width constant 16, shared with BO.
- One natural sub-module: contador_espera, the wait counter with clear/enable and a last-cycle flag (terminal = ULA_LAT-1).

Test Plan:
- Bench pairing: bc_horner is paired with a behavioural BO model.
- Test 1, ULA_LAT=1, A=2, B=3, C=4, Xis=5, start pulse at edge t -> done high only in cycle t+6; S=69; one ls pulse; one lx pulse.
- Test 2, ULA_LAT=3, A=1, B=0, C=0, Xis=0x0100 -> done at t+14; S=0x0000 (wraps mod 2^16); lh asserted only on the third cycle of each ULA state.
- Test 3, rst asserted in the 2nd cycle of MUL2 -> next cycle IDLE with all outputs 0. A later start with A=1, B=1, C=1, Xis=2 gives S=7.
- Test 4, start pulsed again during ADD_B -> ignored: exactly one done, and busy waveform identical to a single run.
- Test 5, start held high for 3 computations (ULA_LAT=1) -> done every 7 cycles; busy low exactly in each DONE and IDLE cycle.
- Test 6, no start for 20 cycles after reset -> busy, done, lx, ls, lh remain 0; m0, m1, m2 remain 00.
